// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// A request is captured at acceptance and its result is committed after a fixed latency.
module mult_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDOp,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1) + 1;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic               busy_r, busy_s, done_r, done_s;
  logic [WIDTH-1:0]   hi_r, hi_s, lo_r, lo_s;
  logic [WIDTH-1:0]   a_r, a_s, b_r, b_s;
  logic [2:0]         op_r, op_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quot_s, rem_s;

  // Product of the captured operands, signed or unsigned by captured opcode
  always_comb begin
    prod_s = {(2*WIDTH){1'b0}};
    if (op_r == OP_MULT) begin
      prod_s = $signed({{WIDTH{a_r[WIDTH-1]}}, a_r}) * $signed({{WIDTH{b_r[WIDTH-1]}}, b_r});
    end else begin
      prod_s = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
    end
  end

  // Quotient/remainder; zero divisor and signed overflow are resolved explicitly
  always_comb begin
    quot_s = {WIDTH{1'b0}};
    rem_s  = {WIDTH{1'b0}};
    if (b_r == {WIDTH{1'b0}}) begin
      quot_s = ALL_ONES;
      rem_s  = a_r;
    end else if (op_r == OP_DIV && a_r == MOST_NEG && b_r == ALL_ONES) begin
      quot_s = a_r;
      rem_s  = {WIDTH{1'b0}};
    end else if (op_r == OP_DIV) begin
      quot_s = $signed(a_r) / $signed(b_r);
      rem_s  = $signed(a_r) % $signed(b_r);
    end else begin
      quot_s = a_r / b_r;
      rem_s  = a_r % b_r;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    hi_s    = hi_r;
    lo_s    = lo_r;
    a_s     = a_r;
    b_s     = b_r;
    op_s    = op_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          case (MDOp)
            OP_MULTU, OP_MULT: begin
              state_s = ST_RUN;
              cnt_s   = CW'(MUL_CYCLES);
              busy_s  = 1'b1;
              a_s     = A;
              b_s     = B;
              op_s    = MDOp;
            end
            OP_DIVU, OP_DIV: begin
              state_s = ST_RUN;
              cnt_s   = CW'(DIV_CYCLES);
              busy_s  = 1'b1;
              a_s     = A;
              b_s     = B;
              op_s    = MDOp;
            end
            OP_MTHI: hi_s = A;
            OP_MTLO: lo_s = A;
            default: state_s = ST_IDLE;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CW'(1)) begin
          state_s = ST_IDLE;
          cnt_s   = {CW{1'b0}};
          busy_s  = 1'b0;
          done_s  = 1'b1;
          if (op_r == OP_MULTU || op_r == OP_MULT) begin
            hi_s = prod_s[2*WIDTH-1:WIDTH];
            lo_s = prod_s[WIDTH-1:0];
          end else begin
            hi_s = rem_s;
            lo_s = quot_s;
          end
        end else begin
          cnt_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CW{1'b0}};
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      op_r    <= 3'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      a_r     <= a_s;
      b_r     <= b_s;
      op_r    <= op_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors, hand sequences for
// busy/reset/MTHI corner cases, and randomized operations against a 64-bit model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [2:0]  mdop;
  logic        start, start1;
  logic        busy, done, busy1, done1;
  logic [31:0] hi, lo, hi1, lo1;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .MDOp(mdop), .start(start),
    .busy(busy), .done(done), .HI(hi), .LO(lo));

  mult_div_unit #(.WIDTH(32), .MUL_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .A(a), .B(b), .MDOp(mdop), .start(start1),
    .busy(busy1), .done(done1), .HI(hi1), .LO(lo1));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  vec_t vecs[6];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, returns {HI, LO}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      3'd0: p = {32'd0, x} * {32'd0, y};
      3'd1: p = 64'(sx * sy);
      3'd2: p = (y == 32'd0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
      3'd3: begin
        if (y == 32'd0) p = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) p = {32'd0, x};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Issue one mul/div, scramble inputs afterwards, check busy length and committed result
  task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input string name);
    int n, cyc;
    n = (op < 3'd2) ? 5 : 10;
    a = x; b = y; mdop = op; start = 1'b1;
    tick;
    start = 1'b0; a = ~x; b = $urandom; mdop = ~op;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (done !== 1'b0) chk({name, "_done_early"}, {63'd0, done}, 64'd0);
      cyc++;
      tick;
    end
    chk({name, "_busy_cycles"}, 64'(cyc), 64'(n));
    chk({name, "_done"}, {63'd0, done}, 64'd1);
    chk({name, "_hilo"}, {hi, lo}, exp);
    tick;
    chk({name, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] hold_hi, hold_lo;
    int cyc;

    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'd0, 32'hFFFFFFFE, 32'd3,          32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{3'd2, 32'h8AC92839, 32'd5,          32'h00000001, 32'h1BC1D4D8};
    vecs[3] = '{3'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{3'd3, 32'h12345678, 32'd0,          32'h12345678, 32'hFFFFFFFF};
    vecs[5] = '{3'd3, 32'h80000000, 32'hFFFFFFFF,   32'h00000000, 32'h80000000};

    reset = 1'b1; start = 1'b0; start1 = 1'b0; a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; mdop = 3'd0;
    tick; tick;
    chk("reset_state", {60'd0, busy, done, busy1, done1}, 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick;

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, $sformatf("vec%0d", i));

    // MTHI while a DIVU is busy must be dropped; HI holds until commit
    hold_hi = hi; hold_lo = lo;
    a = 32'h8AC92839; b = 32'd5; mdop = 3'd2; start = 1'b1;
    tick;
    a = 32'hDEADBEEF; mdop = 3'd4;
    tick; tick; tick;
    chk("busy_mthi_hold", {hi, lo}, {hold_hi, hold_lo});
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin cyc++; tick; end
    chk("busy_mthi_commit", {31'd0, done, hi}, {31'd0, 1'b1, 32'h00000001});
    tick;

    a = 32'hDEADBEEF; mdop = 3'd4; start = 1'b1;
    tick;
    start = 1'b0;
    chk("idle_mthi", {30'd0, busy, done, hi}, {32'd0, 32'hDEADBEEF});
    a = 32'h0BADF00D; mdop = 3'd5; start = 1'b1;
    tick;
    start = 1'b0;
    chk("idle_mtlo", {hi, lo}, {32'hDEADBEEF, 32'h0BADF00D});
    a = 32'h11111111; mdop = 3'd6; start = 1'b1;
    tick;
    mdop = 3'd7;
    tick;
    start = 1'b0;
    tick;
    chk("reserved_op", {30'd0, busy, done, hi}, {32'd0, 32'hDEADBEEF});
    chk("reserved_op_lo", {32'd0, lo}, {32'd0, 32'h0BADF00D});

    // Reset three cycles into a MULT aborts it
    a = 32'h00001234; b = 32'h00005678; mdop = 3'd1; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("abort_state", {30'd0, busy, done, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    do_op(3'd0, 32'hFFFFFFFE, 32'd3, 64'h00000002FFFFFFFA, "post_reset_multu");
    tick;
    chk("abort_no_done", {63'd0, done}, 64'd0);

    // Single-cycle configuration
    a = 32'hFFFFFFFE; b = 32'd3; mdop = 3'd1; start1 = 1'b1;
    tick;
    start1 = 1'b0;
    chk("n1_busy", {62'd0, busy1, done1}, 64'd2);
    tick;
    chk("n1_commit", {62'd0, busy1, done1}, 64'd1);
    chk("n1_hilo", {hi1, lo1}, 64'hFFFFFFFFFFFFFFFA);
    tick;
    chk("n1_done_pulse", {63'd0, done1}, 64'd0);

    // Randomized mul/div with occasional boundary operands
    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [31:0] x, y;
      op = 3'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 5))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 9));
        default: y = y;
      endcase
      r = model(op, x, y);
      do_op(op, x, y, r, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand, HI and LO width.
REQ-002 The block SHALL have parameter MUL_CYCLES, default 5, giving the multiply latency in cycles; legal values are 1 or more.
REQ-003 The block SHALL have parameter DIV_CYCLES, default 10, giving the divide latency in cycles; legal values are 1 or more.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port A, input, WIDTH bits: operand 1 (dividend or multiplicand; the source for MTHI/MTLO).
REQ-007 The block SHALL have port B, input, WIDTH bits: operand 2 (divisor or multiplier).
REQ-008 The block SHALL have port MDOp, input, 3 bits, encoded as: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTHI, 5 MTLO; values 6 and 7 are reserved.
REQ-009 The block SHALL have port start, input, 1 bit: operation request, sampled at the clock edge.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a multiply or divide is in flight.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a multiply or divide result is committed.
REQ-012 The block SHALL have port HI, output, WIDTH bits: product upper half, or remainder.
REQ-013 The block SHALL have port LO, output, WIDTH bits: product lower half, or quotient.

Function
REQ-014 The block SHALL accept a request when start=1 and busy=0 at a rising edge, called edge 0; A, B and MDOp are captured at edge 0, and later changes to them SHALL have no effect on the operation.
REQ-015 For a multiply or divide the block SHALL move from state IDLE to state RUN at edge 0, load a counter with N (N = MUL_CYCLES or DIV_CYCLES), and assert busy from edge 0 through edge N-1, so busy is high for exactly N cycles.
REQ-016 At edge N the block SHALL write HI and LO, clear busy, assert done for one cycle, and return to IDLE; a new start accepted at edge N+1 is legal.
REQ-017 MULTU SHALL compute {HI,LO} = the unsigned 2*WIDTH-bit product; MULT SHALL compute the two's-complement signed 2*WIDTH-bit product.
REQ-018 DIVU SHALL produce an unsigned quotient in LO and remainder in HI; DIV SHALL produce a signed quotient truncated toward zero, with the remainder taking the dividend's sign.
REQ-019 On divide by zero (B=0, DIV or DIVU), the block SHALL set LO to all ones and HI to A, using the normal DIV_CYCLES latency.
REQ-020 On signed overflow (DIV with A = most-negative value and B = all ones), the block SHALL set LO = A and HI = 0.
REQ-021 MTHI and MTLO accepted at edge 0 SHALL write A to HI or LO respectively at edge 0, with no change to busy and no done pulse.
REQ-022 While busy=1, start SHALL be ignored for every MDOp, including MTHI and MTLO, and HI/LO SHALL hold their previous values until edge N.
REQ-023 Start with a reserved MDOp SHALL have no effect on any state.
REQ-024 In a 1-cycle configuration (N=1), busy SHALL be high for one cycle and the result SHALL be written at edge 1.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL clear HI, LO, busy, done and the counter to 0 and enter IDLE; this takes priority over start.
REQ-026 Reset asserted during RUN SHALL abort the operation, with no result written and no done pulse.

Verification
REQ-027 The bench SHALL cover MULT with A=32'hFFFFFFFE and B=3, requiring busy high for 5 cycles and then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA, done=1 for one cycle.
REQ-028 The bench SHALL cover MULTU with A=32'hFFFFFFFE and B=3, requiring HI=32'h00000002 and LO=32'hFFFFFFFA after 5 cycles.
REQ-029 The bench SHALL cover DIVU with A=32'h8AC92839 and B=5, requiring LO=32'h1BC1D4D8 and HI=32'h00000001 after 10 cycles; DIV with A=32'hFFFFFFF9 and B=2 SHALL give LO=32'hFFFFFFFD and HI=32'hFFFFFFFF.
REQ-030 The bench SHALL cover DIV with A=32'h12345678 and B=0, requiring LO=32'hFFFFFFFF and HI=32'h12345678; DIV with A=32'h80000000 and B=32'hFFFFFFFF SHALL give LO=32'h80000000 and HI=0.
REQ-031 The bench SHALL cover MTHI with A=32'hDEADBEEF issued while a DIVU is busy, requiring it to be ignored so that HI equals the DIVU remainder at commit; the same MTHI issued when idle SHALL give HI=32'hDEADBEEF on the next cycle with no done pulse.
REQ-032 The bench SHALL cover reset asserted 3 cycles into a MULT, requiring HI=LO=0, busy=0, no done pulse, and a new MULTU accepted on the first cycle after reset is released completing normally.
